// File: rtl/mem_req_issue_pkg.sv
// Shared types for the memory-stage request issuer and data bus.
// Holds dbus structs, access-size and issuer-state enums.
package mem_req_issue_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2
  } msize_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } mreq_state_t;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    msize_t            size;
    logic [STRB_W-1:0] strobe;
    logic [DATA_W-1:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic              addr_ok;
    logic              data_ok;
    logic [DATA_W-1:0] data;
  } dbus_resp_t;

  function automatic logic misaligned(
    input logic [1:0] a,
    input msize_t     s
  );
    logic r;
    r = 1'b0;
    unique case (1'b1)
      (s == MSIZE2): r = a[0];
      (s == MSIZE4): r = (a != 2'b00);
      default:       r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_req_issue_lane.sv
// Store lane generator: byte strobes and replicated write data.
// Ports: i_addr_lo, i_size, i_wdata -> o_strobe, o_data.
module mem_lane_gen
  import mem_req_issue_pkg::*;
(
  input  logic [1:0]        i_addr_lo,
  input  msize_t            i_size,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [STRB_W-1:0] o_strobe,
  output logic [DATA_W-1:0] o_data
);

  always_comb begin
    o_strobe = '0;
    o_data   = i_wdata;
    unique case (1'b1)
      (i_size == MSIZE1): begin
        o_strobe = 4'b0001 << i_addr_lo;
        o_data   = {4{i_wdata[7:0]}};
      end
      (i_size == MSIZE2): begin
        o_strobe = i_addr_lo[1] ? 4'b1100
                                : 4'b0011;
        o_data   = {2{i_wdata[15:0]}};
      end
      default: begin
        o_strobe = 4'b1111;
        o_data   = i_wdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_req_issue.sv
// Memory-stage dbus request issuer: issues base+offset requests,
// holds valid until data_ok, holds the response for a stalled
// pipeline and raises mem_halt while a transaction is open.
// Ports: clk, resetn, en, mem_read, mem_write, base, offset,
// msize, wdata, flush, stall_in, dreq, dresp, resp_out,
// mem_halt, exc_adel, exc_ades.
// Option MEM_ALIGN_CHECK_EN: block misaligned ops and raise
// exc_adel/exc_ades instead of issuing them.
module mem_req_issue
  import mem_req_issue_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              en,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] offset,
  input  msize_t            msize,
  input  logic [DATA_W-1:0] wdata,
  input  logic              flush,
  input  logic              stall_in,
  output dbus_req_t         dreq,
  input  dbus_resp_t        dresp,
  output dbus_resp_t        resp_out,
  output logic              mem_halt,
  output logic              exc_adel,
  output logic              exc_ades
);

  mreq_state_t       r_state;
  dbus_req_t         r_req;
  logic [DATA_W-1:0] r_data;

  logic [ADDR_W-1:0] w_addr;
  logic [3:0]        w_strb;
  logic [DATA_W-1:0] w_ldata;
  logic              w_addr_err;
  logic              w_op;
  logic              w_idle;
  logic              w_go;
  dbus_req_t         w_req_new;

  assign w_addr = base + offset;

  mem_lane_gen u_lane (
    .i_addr_lo (w_addr[1:0]),
    .i_size    (msize),
    .i_wdata   (wdata),
    .o_strobe  (w_strb),
    .o_data    (w_ldata)
  );

`ifdef MEM_ALIGN_CHECK_EN
  assign w_addr_err = misaligned(w_addr[1:0], msize);
`else
  assign w_addr_err = 1'b0;
`endif

  assign w_op   = en & (mem_read | mem_write);
  assign w_idle = (r_state == IDLE);
  // resetn gates issue so reset drops valid with no clock edge
  assign w_go   = resetn & w_idle & w_op
                & ~flush & ~w_addr_err;

  always_comb begin
    w_req_new        = '0;
    w_req_new.valid  = 1'b1;
    w_req_new.addr   = w_addr;
    w_req_new.size   = msize;
    if (mem_write) begin
      w_req_new.strobe = w_strb;
      w_req_new.data   = w_ldata;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  assign exc_adel = resetn & w_idle & en
                  & w_addr_err & mem_read;
  assign exc_ades = resetn & w_idle & en
                  & w_addr_err & mem_write;
`else
  assign exc_adel = 1'b0;
  assign exc_ades = 1'b0;
`endif

  always_comb begin
    dreq             = w_req_new;
    dreq.valid       = 1'b0;
    resp_out         = dresp;
    resp_out.data_ok = dresp.data_ok & ~flush;
    mem_halt         = 1'b0;
    if (!resetn) begin
      resp_out = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          dreq.valid = w_go;
          mem_halt   = w_go & ~dresp.data_ok;
        end
        BUSY: begin
          dreq       = r_req;
          dreq.valid = 1'b1;
          mem_halt   = ~dresp.data_ok;
        end
        HOLD: begin
          dreq             = r_req;
          dreq.valid       = 1'b0;
          resp_out.addr_ok = 1'b1;
          resp_out.data_ok = 1'b1;
          resp_out.data    = r_data;
        end
        DRAIN: begin
          dreq             = r_req;
          dreq.valid       = 1'b1;
          resp_out.data_ok = 1'b0;
          mem_halt         = 1'b1;
        end
        default: begin
          dreq.valid = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_req   <= '0;
      r_data  <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_go) begin
            r_req <= w_req_new;
            if (dresp.data_ok) begin
              r_data <= dresp.data;
              if (stall_in)
                r_state <= HOLD;
            end else begin
              r_state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (dresp.data_ok) begin
            if (flush) begin
              r_state <= IDLE;
            end else begin
              r_data  <= dresp.data;
              r_state <= stall_in ? HOLD
                                  : IDLE;
            end
          end else if (flush) begin
            r_state <= DRAIN;
          end
        end
        HOLD: begin
          if (!stall_in || flush)
            r_state <= IDLE;
        end
        DRAIN: begin
          if (dresp.data_ok)
            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
